// File: rtl/mult_pkg.sv
// Shared multiplier package: default widths and common datapath typedefs.
package mult_pkg;

    localparam int PROD_W = 16;
    localparam int CNT_W  = 32;

    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [CNT_W-1:0]  stat_t;

endpackage

// File: rtl/pp_final_cpa_pipe_if.sv
// Handshake bundle between the compressor tree, the final CPA pipe and the
// product consumer. The slave modport is the pipe's view; master is the
// environment's view (tree on the input side, consumer on the output side).
// The golden-reference field exists only when PP_FINAL_CPA_ERR_STAT_EN is defined.
interface pp_final_cpa_pipe_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_sum;
    logic [W-1:0] in_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_prod;
    logic         out_cout;
`ifdef PP_FINAL_CPA_ERR_STAT_EN
    logic [W-1:0] in_ref;

    modport slave  (input  in_valid, in_sum, in_carry, in_ref, out_ready,
                    output in_ready, out_valid, out_prod, out_cout);
    modport master (output in_valid, in_sum, in_carry, in_ref, out_ready,
                    input  in_ready, out_valid, out_prod, out_cout);
`else
    modport slave  (input  in_valid, in_sum, in_carry, out_ready,
                    output in_ready, out_valid, out_prod, out_cout);
    modport master (output in_valid, in_sum, in_carry, out_ready,
                    input  in_ready, out_valid, out_prod, out_cout);
`endif
endinterface

// File: rtl/cpa_slice_add.sv
// Combinational WIDTH-bit slice adder with carry-in and carry-out.
module cpa_slice_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    // One extra bit captures the carry out of the slice.
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/pp_final_cpa_pipe.sv
// Two-stage pipelined final carry-propagate adder behind the compressor tree.
// Stage 1 adds the low slice and registers the untouched high slices; stage 2
// finishes the high slice with the stage-1 carry. Valid/ready on both sides,
// max occupancy two items, one product per cycle.
// Optional macro PP_FINAL_CPA_ERR_STAT_EN adds a reference-product pipe and
// saturating error statistics (txn count, mismatch count, sum of |error|).
module pp_final_cpa_pipe
    import mult_pkg::*;
#(
    parameter int W    = PROD_W,
    parameter int LO_W = W / 2
`ifdef PP_FINAL_CPA_ERR_STAT_EN
    ,
    parameter int CNT_W = mult_pkg::CNT_W
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    pp_final_cpa_pipe_if.slave bus
`ifdef PP_FINAL_CPA_ERR_STAT_EN
    ,
    input  logic               stat_clr,
    output logic [CNT_W-1:0]   stat_txn,
    output logic [CNT_W-1:0]   stat_err_cnt,
    output logic [CNT_W-1:0]   stat_err_sum
`endif
);

    localparam int HI_W = W - LO_W;

    logic            r_s1_valid;
    logic [LO_W-1:0] r_s1_lo;
    logic            r_s1_c1;
    logic [HI_W-1:0] r_s1_sum_hi;
    logic [HI_W-1:0] r_s1_carry_hi;
    logic            r_s2_valid;
    logic [W-1:0]    r_out_prod;
    logic            r_out_cout;

    logic            w_adv1;
    logic            w_adv2;
    logic [LO_W-1:0] w_lo_sum;
    logic            w_lo_cout;
    logic [HI_W-1:0] w_hi_sum;
    logic            w_hi_cout;

    // A stage may load when it is empty or its content moves on this cycle.
    assign w_adv2 = !r_s2_valid || bus.out_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_prod  = r_out_prod;
    assign bus.out_cout  = r_out_cout;

    cpa_slice_add #(.WIDTH(LO_W)) u_lo_add (
        .i_a    (bus.in_sum[LO_W-1:0]),
        .i_b    (bus.in_carry[LO_W-1:0]),
        .i_cin  (1'b0),
        .o_sum  (w_lo_sum),
        .o_cout (w_lo_cout)
    );

    cpa_slice_add #(.WIDTH(HI_W)) u_hi_add (
        .i_a    (r_s1_sum_hi),
        .i_b    (r_s1_carry_hi),
        .i_cin  (r_s1_c1),
        .o_sum  (w_hi_sum),
        .o_cout (w_hi_cout)
    );

    // Stage 1: low-slice sum plus carry, high slices passed through raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_lo       <= '0;
            r_s1_c1       <= 1'b0;
            r_s1_sum_hi   <= '0;
            r_s1_carry_hi <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_lo       <= w_lo_sum;
                r_s1_c1       <= w_lo_cout;
                r_s1_sum_hi   <= bus.in_sum[W-1:LO_W];
                r_s1_carry_hi <= bus.in_carry[W-1:LO_W];
            end
        end
    end

    // Stage 2: high-slice completion; output held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_prod <= '0;
            r_out_cout <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_prod <= {w_hi_sum, r_s1_lo};
                r_out_cout <= w_hi_cout;
            end
        end
    end

`ifdef PP_FINAL_CPA_ERR_STAT_EN
    logic [W-1:0]     r_s1_ref;
    logic [W-1:0]     r_s2_ref;
    logic [CNT_W-1:0] r_stat_txn;
    logic [CNT_W-1:0] r_stat_err_cnt;
    logic [CNT_W-1:0] r_stat_err_sum;
    logic             w_xfer;
    logic [W:0]       w_diff_pos;
    logic [W:0]       w_diff_neg;
    logic [W:0]       w_abs;
    logic [CNT_W:0]   w_sum_ext;

    assign w_xfer     = r_s2_valid && bus.out_ready;
    assign w_diff_pos = {1'b0, r_out_prod} - {1'b0, r_s2_ref};
    assign w_diff_neg = {1'b0, r_s2_ref} - {1'b0, r_out_prod};
    assign w_abs      = w_diff_pos[W] ? w_diff_neg : w_diff_pos;
    assign w_sum_ext  = {1'b0, r_stat_err_sum} + (CNT_W+1)'(w_abs);

    assign stat_txn     = r_stat_txn;
    assign stat_err_cnt = r_stat_err_cnt;
    assign stat_err_sum = r_stat_err_sum;

    // Reference product travels in lockstep with the data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_ref <= '0;
            r_s2_ref <= '0;
        end else begin
            if (w_adv1 && bus.in_valid) r_s1_ref <= bus.in_ref;
            if (w_adv2 && r_s1_valid)   r_s2_ref <= r_s1_ref;
        end
    end

    // Saturating statistics; a clear overrides a coincident transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_txn     <= '0;
            r_stat_err_cnt <= '0;
            r_stat_err_sum <= '0;
        end else if (stat_clr) begin
            r_stat_txn     <= '0;
            r_stat_err_cnt <= '0;
            r_stat_err_sum <= '0;
        end else if (w_xfer) begin
            if (!(&r_stat_txn)) r_stat_txn <= r_stat_txn + 1'b1;
            if ((r_out_prod != r_s2_ref) && !(&r_stat_err_cnt))
                r_stat_err_cnt <= r_stat_err_cnt + 1'b1;
            r_stat_err_sum <= w_sum_ext[CNT_W] ? '1 : w_sum_ext[CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_pp_final_cpa_pipe.sv
// Self-checking bench for pp_final_cpa_pipe: directed vector table, random
// streaming against a queue model, backpressure, async reset and (when the
// statistics macro is defined) the error counters.
module tb_pp_final_cpa_pipe;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pp_final_cpa_pipe_if #(.W(W)) bus ();

`ifdef PP_FINAL_CPA_ERR_STAT_EN
    logic        stat_clr;
    logic [31:0] stat_txn;
    logic [31:0] stat_err_cnt;
    logic [31:0] stat_err_sum;
`endif

    pp_final_cpa_pipe #(.W(W), .LO_W(W / 2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus)
`ifdef PP_FINAL_CPA_ERR_STAT_EN
        ,
        .stat_clr     (stat_clr),
        .stat_txn     (stat_txn),
        .stat_err_cnt (stat_err_cnt),
        .stat_err_sum (stat_err_sum)
`endif
    );

    typedef struct {
        logic [15:0] sum;
        logic [15:0] carry;
        logic [15:0] prod;
        logic        cout;
    } vec_t;

    vec_t vecs [8];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single item into an empty pipe with the consumer always ready.
    task automatic send_one(input logic [15:0] s, input logic [15:0] c, input logic [15:0] r,
                            input logic [15:0] ep, input logic ec, input logic clr_on_xfer,
                            input string nm);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sum    = s;
        bus.in_carry  = c;
`ifdef PP_FINAL_CPA_ERR_STAT_EN
        bus.in_ref    = r;
`endif
        #1;
        chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk({nm, "_not_early"}, 64'(bus.out_valid), 64'd0);
        tick();
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_prod"}, 64'(bus.out_prod), 64'(ep));
        chk({nm, "_cout"}, 64'(bus.out_cout), 64'(ec));
`ifdef PP_FINAL_CPA_ERR_STAT_EN
        stat_clr = clr_on_xfer;
`endif
        tick();
`ifdef PP_FINAL_CPA_ERR_STAT_EN
        stat_clr = 1'b0;
`endif
    endtask

    // Random stream of n items; consumer stalled for the first stall_len cycles.
    task automatic stream(input int n, input int stall_len, input string nm,
                          output int ready_drops, output int acc_in_stall, output int got);
        logic [16:0] q[$];
        logic [16:0] e;
        logic [15:0] s;
        logic [15:0] c;
        int          sent;
        sent = 0;
        got = 0;
        ready_drops = 0;
        acc_in_stall = 0;
        s = 16'($urandom);
        c = 16'($urandom);
        for (int cyc = 0; cyc < n + stall_len + 20 && got < n; cyc++) begin
            bus.out_ready = (cyc >= stall_len);
            bus.in_valid  = (sent < n);
            bus.in_sum    = s;
            bus.in_carry  = c;
`ifdef PP_FINAL_CPA_ERR_STAT_EN
            bus.in_ref    = '0;
`endif
            #1;
            if (bus.in_valid && !bus.in_ready) ready_drops++;
            if (stall_len > 0 && cyc >= 2 && cyc < stall_len) begin
                chk({nm, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
                chk({nm, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
                chk({nm, "_hold_data"}, 64'({bus.out_cout, bus.out_prod}), 64'(q[0]));
            end
            if (cyc < stall_len && bus.in_valid && bus.in_ready) acc_in_stall++;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back({1'b0, s} + {1'b0, c});
                sent++;
                s = 16'($urandom);
                c = 16'($urandom);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL %s_extra: unexpected product 0x%0h", nm, bus.out_prod);
                end else begin
                    e = q.pop_front();
                    chk({nm, "_order"}, 64'({bus.out_cout, bus.out_prod}), 64'(e));
                end
                got++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    int drops;
    int acc;
    int got;

    initial begin
        vecs[0] = '{16'h1234, 16'h0F0F, 16'h2143, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 16'h0100, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
        vecs[5] = '{16'h00F0, 16'h0F10, 16'h1000, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = '0;
        bus.out_ready = 1'b0;
`ifdef PP_FINAL_CPA_ERR_STAT_EN
        bus.in_ref    = '0;
        stat_clr      = 1'b0;
`endif
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_prod", 64'(bus.out_prod), 64'd0);
        chk("rst_out_cout", 64'(bus.out_cout), 64'd0);
`ifdef PP_FINAL_CPA_ERR_STAT_EN
        chk("rst_stat_txn", 64'(stat_txn), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 8; i++)
            send_one(vecs[i].sum, vecs[i].carry, 16'h0, vecs[i].prod, vecs[i].cout, 1'b0,
                     $sformatf("vec%0d", i));

        stream(100, 0, "stream", drops, acc, got);
        chk("stream_ready_drops", 64'(drops), 64'd0);
        chk("stream_count", 64'(got), 64'd100);

        stream(6, 5, "bp", drops, acc, got);
        chk("bp_accepted_in_stall", 64'(acc), 64'd2);
        chk("bp_count", 64'(got), 64'd6);

        // Fill both stages, then reset between clock edges.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sum    = 16'h1111;
        bus.in_carry  = 16'h2222;
        tick();
        bus.in_sum    = 16'h3333;
        bus.in_carry  = 16'h4444;
        tick();
        bus.in_valid  = 1'b0;
        #1;
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_out_prod", 64'(bus.out_prod), 64'h3333);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_prod", 64'(bus.out_prod), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        send_one(16'h0101, 16'h0202, 16'h0, 16'h0303, 1'b0, 1'b0, "post_rst");

`ifdef PP_FINAL_CPA_ERR_STAT_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_txn", 64'(stat_txn), 64'd0);
        send_one(16'h1000, 16'h0234, 16'h1234, 16'h1234, 1'b0, 1'b0, "st0");
        send_one(16'h1000, 16'h0234, 16'h1234, 16'h1234, 1'b0, 1'b0, "st1");
        send_one(16'h1000, 16'h0234, 16'h1237, 16'h1234, 1'b0, 1'b0, "st2");
        send_one(16'h1000, 16'h0234, 16'h122F, 16'h1234, 1'b0, 1'b0, "st3");
        chk("stat_txn", 64'(stat_txn), 64'd4);
        chk("stat_err_cnt", 64'(stat_err_cnt), 64'd2);
        chk("stat_err_sum", 64'(stat_err_sum), 64'd8);
        send_one(16'h1000, 16'h0234, 16'h0000, 16'h1234, 1'b0, 1'b1, "st4");
        chk("clrx_txn", 64'(stat_txn), 64'd0);
        chk("clrx_err_cnt", 64'(stat_err_cnt), 64'd0);
        chk("clrx_err_sum", 64'(stat_err_sum), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
